harvest_sense_scheduler: RTL
============================

// Module: harvest_sense_scheduler
// PURPOSE
//  Sequences one harvest-classification cycle:
//    1. fire an ultrasonic ping and time its echo;
//    2. wait out ringdown;
//    3. arm the pixel accumulators for exactly one camera frame;
//    4. kick the BNN and report completion.
//  Sits between the raw sensor pins/edge detectors and the feature/BNN datapath.
//  Guarantees the acoustic and optical measurements never overlap and always pair up.
// PARAMETERS
//  PING_WIDTH     250        trig_out high time, clk cycles (>=1)
//  ECHO_TIMEOUT   1500000    max cycles in ECHO_WAIT before echo error
//  SETTLE_CYCLES  50000      ringdown gap between echo end and frame arm (>=1)
//  FRAME_TIMEOUT  2000000    max cycles in FRAME_ARM+FRAME_WAIT before frame error
//  CNT_W          24         shared phase-counter width; must hold every count above
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous, active-high reset
//  ena          in   1   0 = freeze all state, counters and outputs
//  start        in   1   1-cycle request to run one cycle; ignored while busy
//  auto_mode    in   1   1 = restart automatically from IDLE every time
//  echo_in      in   1   ultrasonic echo, already synchronised to clk
//  vsync_rise   in   1   1-cycle pulse: frame start (from capture edge detect)
//  vsync_fall   in   1   1-cycle pulse: frame end
//  infer_done   in   1   1-cycle pulse from BNN: inference complete
//  trig_out     out  1   ultrasonic trigger
//  frame_en     out  1   enables pixel accumulation for the current frame
//  infer_start  out  1   1-cycle pulse to BNN
//  busy         out  1   1 in every state except IDLE
//  result_valid out  1   1-cycle pulse: cycle finished (with or without errors)
//  echo_cycles  out  16  last echo width in clk cycles, saturating
//  err_echo     out  1   echo timed out this cycle
//  err_frame    out  1   frame timed out this cycle
//  cycle_count  out  8   completed cycles, wraps 255->0
// BEHAVIOUR
//  Reset values
//    - All outputs 0; state IDLE; counter 0.
//    - Reset is async: trig_out/frame_en drop the instant rst asserts, even mid-cycle.
//  General
//    - All outputs registered.
//    - On every state entry the phase counter clears to 0.
//    - ena=0 holds every register; pulse outputs are forced 0 while ena=0.
//  IDLE
//    - start or auto_mode -> PING next cycle.
//    - err_echo and err_frame clear on that transition.
//  PING
//    - trig_out=1 for exactly PING_WIDTH cycles; first high cycle is the cycle after start.
//    - Then ECHO_WAIT.
//  ECHO_WAIT
//    - Waits for echo_in high, then counts cycles while high.
//    - On echo_in falling, latch the count into echo_cycles (saturates at 16'hFFFF) -> SETTLE.
//    - Timeout: counter reaches ECHO_TIMEOUT (wait + width combined) ->
//      err_echo=1, echo_cycles=16'hFFFF, -> SETTLE.
//    - echo_in already high on entry counts as the start of the echo.
//  SETTLE
//    - Holds SETTLE_CYCLES cycles -> FRAME_ARM.
//  FRAME_ARM
//    - vsync_rise -> FRAME_WAIT; frame_en=1 from the next cycle.
//    - vsync_fall is ignored in FRAME_ARM (no partial frames).
//  FRAME_WAIT
//    - vsync_fall -> frame_en=0 next cycle -> INFER.
//    - vsync_rise is ignored in FRAME_WAIT.
//  Frame timeout
//    - Counter runs across ARM and WAIT without clearing between them.
//    - At FRAME_TIMEOUT: frame_en=0, err_frame=1, -> REPORT. BNN not started.
//  INFER
//    - infer_start pulses on the first cycle in INFER.
//    - infer_done is sampled only from the following cycle; on it -> REPORT.
//  REPORT
//    - result_valid=1 for one cycle; cycle_count+=1; -> IDLE.
//    - In auto_mode the next PING starts one cycle after REPORT.
//  Cycle-level rules
//    - start asserted in the same cycle as REPORT is ignored.
//    - A pulse input asserted while ena=0 is lost.
// TESTING
//  Test parameters: PING_WIDTH=4, ECHO_TIMEOUT=100, SETTLE_CYCLES=8, FRAME_TIMEOUT=200.
//  1 Nominal cycle
//    start@0, echo high cycles 10..29, vsync_rise@60, vsync_fall@120, infer_done 3 cycles after infer_start
//    -> trig_out high 1..4; echo_cycles=20; frame_en high 61..120;
//       one infer_start; result_valid once; cycle_count=1; no errors.
//  2 Echo timeout
//    echo_in held 0 -> err_echo=1, echo_cycles=16'hFFFF, frame phase still runs,
//    result_valid fires, cycle_count=1.
//  3 Frame timeout
//    no vsync pulses -> err_frame=1 exactly 200 cycles after FRAME_ARM entry;
//    infer_start never pulses; result_valid fires.
//  4 Stray edges
//    vsync_fall in FRAME_ARM, vsync_rise in FRAME_WAIT, start while busy
//    -> all ignored; frame_en spans only the valid rise..fall; one result_valid.
//  5 Control
//    - auto_mode=1 for 3 cycles -> cycle_count 0->3; PING starts one cycle after each REPORT.
//    - ena=0 held 50 cycles mid-PING -> trig_out stays high and total high time is still 4 active cycles.
//  6 Reset mid-FRAME_WAIT
//    - trig_out/frame_en fall immediately.
//    - After release: IDLE, cycle_count=0, echo_cycles=0.
//    - 255 completed cycles followed by one more -> cycle_count wraps to 0.

Source files
------------

// File: rtl/harvest_sense_scheduler.sv
// Sequences one harvest-classification cycle: ultrasonic ping, echo timing, ringdown,
// one armed camera frame, then a BNN kick, so acoustic and optical data always pair up.
module harvest_sense_scheduler #(
    parameter int unsigned PING_WIDTH    = 250,
    parameter int unsigned ECHO_TIMEOUT  = 1500000,
    parameter int unsigned SETTLE_CYCLES = 50000,
    parameter int unsigned FRAME_TIMEOUT = 2000000,
    parameter int unsigned CNT_W         = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        start,
    input  logic        auto_mode,
    input  logic        echo_in,
    input  logic        vsync_rise,
    input  logic        vsync_fall,
    input  logic        infer_done,
    output logic        trig_out,
    output logic        frame_en,
    output logic        infer_start,
    output logic        busy,
    output logic        result_valid,
    output logic [15:0] echo_cycles,
    output logic        err_echo,
    output logic        err_frame,
    output logic [7:0]  cycle_count
);

    localparam logic [CNT_W-1:0] PING_LAST   = CNT_W'(PING_WIDTH - 1);
    localparam logic [CNT_W-1:0] ECHO_LAST   = CNT_W'(ECHO_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StPing, StEchoWait, StSettle, StFrameArm, StFrameWait, StInfer, StReport
    } state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      echo_w;
    logic             infer_start_q;
    logic             result_valid_q;

    // Pulses are held with the rest of the state while frozen, but must not leak out.
    assign infer_start  = infer_start_q & ena;
    assign result_valid = result_valid_q & ena;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= StIdle;
            cnt            <= '0;
            echo_w         <= '0;
            trig_out       <= 1'b0;
            frame_en       <= 1'b0;
            infer_start_q  <= 1'b0;
            busy           <= 1'b0;
            result_valid_q <= 1'b0;
            echo_cycles    <= '0;
            err_echo       <= 1'b0;
            err_frame      <= 1'b0;
            cycle_count    <= '0;
        end else if (ena) begin
            case (state)
                StIdle: begin
                    if (start || auto_mode) begin
                        state     <= StPing;
                        cnt       <= '0;
                        trig_out  <= 1'b1;
                        busy      <= 1'b1;
                        err_echo  <= 1'b0;
                        err_frame <= 1'b0;
                    end
                end
                StPing: begin
                    if (cnt == PING_LAST) begin
                        state    <= StEchoWait;
                        cnt      <= '0;
                        trig_out <= 1'b0;
                        echo_w   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StEchoWait: begin
                    if (echo_in && echo_w != 16'hFFFF) begin
                        echo_w <= echo_w + 16'd1;
                    end
                    // A nonzero width means the echo has been seen; a low sample now is its end.
                    if (!echo_in && echo_w != '0) begin
                        echo_cycles <= echo_w;
                        state       <= StSettle;
                        cnt         <= '0;
                    end else if (cnt == ECHO_LAST) begin
                        err_echo    <= 1'b1;
                        echo_cycles <= 16'hFFFF;
                        state       <= StSettle;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StSettle: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= StFrameArm;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StFrameArm: begin
                    // The frame budget spans ARM and WAIT, so the counter keeps running.
                    if (vsync_rise) begin
                        state    <= StFrameWait;
                        frame_en <= 1'b1;
                        cnt      <= cnt + 1'b1;
                    end else if (cnt >= FRAME_LAST) begin
                        err_frame      <= 1'b1;
                        state          <= StReport;
                        cnt            <= '0;
                        result_valid_q <= 1'b1;
                        cycle_count    <= cycle_count + 8'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StFrameWait: begin
                    if (vsync_fall) begin
                        state         <= StInfer;
                        frame_en      <= 1'b0;
                        infer_start_q <= 1'b1;
                        cnt           <= '0;
                    end else if (cnt >= FRAME_LAST) begin
                        frame_en       <= 1'b0;
                        err_frame      <= 1'b1;
                        state          <= StReport;
                        cnt            <= '0;
                        result_valid_q <= 1'b1;
                        cycle_count    <= cycle_count + 8'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StInfer: begin
                    infer_start_q <= 1'b0;
                    cnt           <= CNT_W'(1);
                    if (cnt != '0 && infer_done) begin
                        state          <= StReport;
                        cnt            <= '0;
                        result_valid_q <= 1'b1;
                        cycle_count    <= cycle_count + 8'd1;
                    end
                end
                StReport: begin
                    result_valid_q <= 1'b0;
                    cnt            <= '0;
                    if (auto_mode) begin
                        state     <= StPing;
                        trig_out  <= 1'b1;
                        err_echo  <= 1'b0;
                        err_frame <= 1'b0;
                    end else begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
